// File: rtl/dmem_bus_adapter.sv
// -----------------------------------------------------------------------------
// dmem_bus_adapter
//
// Bridges a core's single-cycle data-memory request onto a valid/ready word
// bus with a separate read-data return (rvalid). Byte and half accesses are
// turned into byte enables plus lane-replicated store data. Load data is
// shifted down and zero-extended before it reaches the core. Misaligned
// half/word accesses are rejected in the request cycle and never reach the bus.
//
// Optional feature (compile-time macro DMEM_BUS_TIMEOUT_EN):
//   When the macro is defined, a transaction that spends TIMEOUT_CYCLES cycles
//   in REQ+WAIT_RD is abandoned. The FSM goes to DONE with zero load data and
//   core_err_o pulses. Without the macro, waits are unbounded and core_err_o
//   is tied low.
//
// Ports
//   clk_i, reset_ni     clock, asynchronous active-low reset
//   core_req_i          access requested this cycle
//   core_we_i           1 = store, 0 = load
//   core_addr_i[31:0]   byte address
//   core_size_i[1:0]    0 = byte, 1 = half, 2/3 = word
//   core_wdata_i[31:0]  store data, LSB-justified
//   core_rdata_o[31:0]  load data, LSB-justified, zero-extended, held
//   core_stall_o        hold the core pipeline
//   core_misaligned_o   misaligned access pulse (request cycle)
//   core_err_o          bus timeout pulse (DONE cycle of an aborted access)
//   bus_valid_o/ready_i request handshake
//   bus_we_o            write
//   bus_addr_o[31:0]    word address (bits [1:0] = 0)
//   bus_be_o[3:0]       byte enables
//   bus_wdata_o[31:0]   lane-replicated store data
//   bus_rdata_i[31:0]   read data, valid with bus_rvalid_i
// -----------------------------------------------------------------------------
module dmem_bus_adapter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [31:0] core_addr_i,
    input  logic [1:0]  core_size_i,
    input  logic [31:0] core_wdata_i,
    output logic [31:0] core_rdata_o,
    output logic        core_stall_o,
    output logic        core_misaligned_o,
    output logic        core_err_o,
    output logic        bus_valid_o,
    input  logic        bus_ready_i,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_rvalid_i
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t     state;
    state_t     state_next;

    logic [1:0] size_q;      // access size of the transaction in flight
    logic [1:0] off_q;       // byte offset within the word
    logic       misaligned;  // current core request breaks natural alignment
    logic       accept;      // IDLE takes the core request this cycle
    logic       timeout;     // wait budget exhausted this cycle
    logic       abort;       // leaving for DONE because of timeout

    // A zero budget would abandon every transaction in its first cycle.
    if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be nonzero");
    end

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    is_misaligned = 1'b0;
            2'd1:    is_misaligned = off[0];
            default: is_misaligned = (off != 2'd0);
        endcase
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    lane_be = 4'b0001 << off;
            2'd1:    lane_be = 4'b0011 << off;
            default: lane_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] size, input logic [31:0] data);
        case (size)
            2'd0:    lane_wdata = {4{data[7:0]}};
            2'd1:    lane_wdata = {2{data[15:0]}};
            default: lane_wdata = data;
        endcase
    endfunction

    function automatic logic [31:0] lane_rdata(input logic [1:0] size, input logic [1:0] off,
                                               input logic [31:0] data);
        logic [31:0] shifted;
        shifted = data >> {off, 3'b000};
        case (size)
            2'd0:    lane_rdata = {24'b0, shifted[7:0]};
            2'd1:    lane_rdata = {16'b0, shifted[15:0]};
            default: lane_rdata = shifted;
        endcase
    endfunction

    assign misaligned = is_misaligned(core_size_i, core_addr_i[1:0]);
    assign accept     = (state == IDLE) && core_req_i && !misaligned;

    // The request-cycle terms depend on core_req_i, which may be active while
    // reset is held; gating with reset_ni keeps the outputs low during reset.
    assign core_stall_o      = reset_ni && (accept || (state == REQ) || (state == WAIT_RD));
    assign core_misaligned_o = reset_ni && (state == IDLE) && core_req_i && misaligned;
    assign bus_valid_o       = (state == REQ);

`ifdef DMEM_BUS_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // wait_cnt counts completed cycles in REQ/WAIT_RD, so the cycle that sees
    // TIMEOUT_CYCLES-1 is the last one allowed.
    assign timeout = ((state == REQ) || (state == WAIT_RD)) &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (accept) begin
                wait_cnt <= '0;
            end else if ((state == REQ) || (state == WAIT_RD)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            // abort is a single-cycle event, so err_q is high only in DONE.
            err_q <= abort;
        end
    end

    assign core_err_o = err_q;
`else
    assign timeout    = 1'b0;
    assign core_err_o = 1'b0;
`endif

    always_comb begin
        state_next = state;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                // A completed store is reported as success even on the last
                // budget cycle; an accepted load still needs its data in time.
                if (bus_ready_i && bus_we_o) begin
                    state_next = DONE;
                end else if (timeout) begin
                    state_next = DONE;
                    abort      = 1'b1;
                end else if (bus_ready_i) begin
                    state_next = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (bus_rvalid_i) begin
                    state_next = DONE;
                end else if (timeout) begin
                    state_next = DONE;
                    abort      = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state        <= IDLE;
            bus_we_o     <= 1'b0;
            bus_addr_o   <= '0;
            bus_be_o     <= '0;
            bus_wdata_o  <= '0;
            size_q       <= '0;
            off_q        <= '0;
            core_rdata_o <= '0;
        end else begin
            state <= state_next;

            // Bus fields are registered at accept so they stay stable through REQ.
            if (accept) begin
                bus_we_o    <= core_we_i;
                bus_addr_o  <= {core_addr_i[31:2], 2'b00};
                bus_be_o    <= lane_be(core_size_i, core_addr_i[1:0]);
                bus_wdata_o <= lane_wdata(core_size_i, core_wdata_i);
                size_q      <= core_size_i;
                off_q       <= core_addr_i[1:0];
            end

            if ((state == WAIT_RD) && bus_rvalid_i) begin
                core_rdata_o <= lane_rdata(size_q, off_q, bus_rdata_i);
            end else if (abort) begin
                core_rdata_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_bus_adapter.sv
module tb_dmem_bus_adapter;

`ifdef DMEM_BUS_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b1;
    logic        core_req_i = 1'b0;
    logic        core_we_i = 1'b0;
    logic [31:0] core_addr_i = '0;
    logic [1:0]  core_size_i = '0;
    logic [31:0] core_wdata_i = '0;
    logic [31:0] core_rdata_o;
    logic        core_stall_o;
    logic        core_misaligned_o;
    logic        core_err_o;
    logic        bus_valid_o;
    logic        bus_ready_i = 1'b0;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_rvalid_i = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_bus_adapter #(.TIMEOUT_CYCLES(TO)) dut (
        .clk_i            (clk_i),
        .reset_ni         (reset_ni),
        .core_req_i       (core_req_i),
        .core_we_i        (core_we_i),
        .core_addr_i      (core_addr_i),
        .core_size_i      (core_size_i),
        .core_wdata_i     (core_wdata_i),
        .core_rdata_o     (core_rdata_o),
        .core_stall_o     (core_stall_o),
        .core_misaligned_o(core_misaligned_o),
        .core_err_o       (core_err_o),
        .bus_valid_o      (bus_valid_o),
        .bus_ready_i      (bus_ready_i),
        .bus_we_o         (bus_we_o),
        .bus_addr_o       (bus_addr_o),
        .bus_be_o         (bus_be_o),
        .bus_wdata_o      (bus_wdata_o),
        .bus_rdata_i      (bus_rdata_i),
        .bus_rvalid_i     (bus_rvalid_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge, where inputs are driven.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_req(input logic we, input logic [31:0] addr, input logic [1:0] size,
                             input logic [31:0] wdata);
        core_req_i   = 1'b1;
        core_we_i    = we;
        core_addr_i  = addr;
        core_size_i  = size;
        core_wdata_i = wdata;
    endtask

    initial begin
        // Reset with a request already pending: nothing may leak out.
        #1;
        reset_ni = 1'b0;
        drive_req(1'b0, 32'h0000_0100, 2'd2, 32'h0);
        tick();
        tick();
        @(negedge clk_i);
        check("rst stall",      32'(core_stall_o),      32'd0);
        check("rst valid",      32'(bus_valid_o),       32'd0);
        check("rst misaligned", 32'(core_misaligned_o), 32'd0);
        check("rst err",        32'(core_err_o),        32'd0);
        check("rst rdata",      core_rdata_o,           32'd0);
        check("rst addr",       bus_addr_o,             32'd0);
        check("rst be",         32'(bus_be_o),          32'd0);
        check("rst wdata",      bus_wdata_o,            32'd0);
        core_req_i = 1'b0;
        reset_ni   = 1'b1;
        tick();

        // Store word 0x11223344 @0x100, ready already high.
        drive_req(1'b1, 32'h0000_0100, 2'd2, 32'h1122_3344);
        bus_ready_i = 1'b1;
        @(negedge clk_i);
        check("stw c1 stall", 32'(core_stall_o), 32'd1);
        check("stw c1 valid", 32'(bus_valid_o),  32'd0);
        tick();
        @(negedge clk_i);
        check("stw c2 stall", 32'(core_stall_o), 32'd1);
        check("stw c2 valid", 32'(bus_valid_o),  32'd1);
        check("stw we",       32'(bus_we_o),     32'd1);
        check("stw be",       32'(bus_be_o),     32'hF);
        check("stw addr",     bus_addr_o,        32'h0000_0100);
        check("stw wdata",    bus_wdata_o,       32'h1122_3344);
        tick();
        core_req_i  = 1'b0;
        bus_ready_i = 1'b0;
        @(negedge clk_i);
        check("stw done stall", 32'(core_stall_o), 32'd0);
        check("stw done valid", 32'(bus_valid_o),  32'd0);
        tick();

        // Load byte @0x103; rvalid seen in IDLE/REQ must be ignored.
        drive_req(1'b0, 32'h0000_0103, 2'd0, 32'h0);
        bus_ready_i  = 1'b1;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'h1234_5678;
        @(negedge clk_i);
        check("ldb c1 stall", 32'(core_stall_o), 32'd1);
        tick();
        @(negedge clk_i);
        check("ldb valid", 32'(bus_valid_o), 32'd1);
        check("ldb we",    32'(bus_we_o),    32'd0);
        check("ldb be",    32'(bus_be_o),    32'h8);
        check("ldb addr",  bus_addr_o,       32'h0000_0100);
        tick();
        bus_ready_i  = 1'b0;
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = 32'hAABB_CCDD;
        @(negedge clk_i);
        check("ldb wait stall", 32'(core_stall_o), 32'd1);
        check("ldb wait valid", 32'(bus_valid_o),  32'd0);
        check("ldb early rvalid ignored", core_rdata_o, 32'd0);
        tick();
        bus_rvalid_i = 1'b1;
        @(negedge clk_i);
        check("ldb wait2 stall", 32'(core_stall_o), 32'd1);
        tick();
        bus_rvalid_i = 1'b0;
        core_req_i   = 1'b0;
        @(negedge clk_i);
        check("ldb done stall", 32'(core_stall_o), 32'd0);
        check("ldb rdata",      core_rdata_o,      32'h0000_00AA);
        tick();
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hFFFF_FFFF;
        @(negedge clk_i);
        check("ldb rdata held", core_rdata_o, 32'h0000_00AA);
        tick();
        bus_rvalid_i = 1'b0;

        // Store half 0xBEEF @0x102, ready arrives after three REQ cycles.
        // Core inputs are scrambled meanwhile to prove the bus side is latched.
        drive_req(1'b1, 32'h0000_0102, 2'd1, 32'h1234_BEEF);
        @(negedge clk_i);
        check("sth c1 stall", 32'(core_stall_o), 32'd1);
        tick();
        core_addr_i  = 32'hFFFF_FFF0;
        core_wdata_i = 32'h0;
        core_size_i  = 2'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("sth hold valid", 32'(bus_valid_o), 32'd1);
            check("sth hold be",    32'(bus_be_o),    32'hC);
            check("sth hold wdata", bus_wdata_o,      32'hBEEF_BEEF);
            check("sth hold addr",  bus_addr_o,       32'h0000_0100);
            tick();
        end
        bus_ready_i = 1'b1;
        @(negedge clk_i);
        check("sth hs valid", 32'(bus_valid_o), 32'd1);
        check("sth hs wdata", bus_wdata_o,      32'hBEEF_BEEF);
        tick();
        bus_ready_i = 1'b0;
        core_req_i  = 1'b0;
        @(negedge clk_i);
        check("sth done stall", 32'(core_stall_o), 32'd0);
        check("sth done valid", 32'(bus_valid_o),  32'd0);
        tick();

        // Misaligned word load @0x101 and half load @0x103.
        drive_req(1'b0, 32'h0000_0101, 2'd2, 32'h0);
        @(negedge clk_i);
        check("misw pulse", 32'(core_misaligned_o), 32'd1);
        check("misw stall", 32'(core_stall_o),      32'd0);
        check("misw valid", 32'(bus_valid_o),       32'd0);
        tick();
        core_req_i = 1'b0;
        @(negedge clk_i);
        check("misw pulse end", 32'(core_misaligned_o), 32'd0);
        check("misw no bus",    32'(bus_valid_o),       32'd0);
        tick();
        drive_req(1'b0, 32'h0000_0103, 2'd1, 32'h0);
        @(negedge clk_i);
        check("mish pulse", 32'(core_misaligned_o), 32'd1);
        check("mish stall", 32'(core_stall_o),      32'd0);
        tick();
        core_req_i = 1'b0;
        @(negedge clk_i);
        check("mish no bus", 32'(bus_valid_o), 32'd0);
        tick();

        // Load half @0x102, rvalid in the first WAIT_RD cycle.
        drive_req(1'b0, 32'h0000_0102, 2'd1, 32'h0);
        bus_ready_i = 1'b1;
        tick();
        @(negedge clk_i);
        check("ldh be", 32'(bus_be_o), 32'hC);
        tick();
        bus_ready_i  = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hAABB_CCDD;
        tick();
        bus_rvalid_i = 1'b0;
        core_req_i   = 1'b0;
        @(negedge clk_i);
        check("ldh rdata", core_rdata_o, 32'h0000_AABB);
        tick();

`ifdef DMEM_BUS_TIMEOUT_EN
        // Load with ready held low: abandoned after TO cycles in REQ.
        drive_req(1'b0, 32'h0000_0100, 2'd3, 32'h0);
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            check("to wait valid", 32'(bus_valid_o), 32'd1);
            check("to wait err",   32'(core_err_o),  32'd0);
            tick();
        end
        core_req_i = 1'b0;
        @(negedge clk_i);
        check("to err",   32'(core_err_o),   32'd1);
        check("to rdata", core_rdata_o,      32'd0);
        check("to stall", 32'(core_stall_o), 32'd0);
        check("to valid", 32'(bus_valid_o),  32'd0);
        tick();
        @(negedge clk_i);
        check("to err end", 32'(core_err_o), 32'd0);
        tick();
`else
        // Without the timeout the adapter waits indefinitely for ready.
        drive_req(1'b0, 32'h0000_0100, 2'd3, 32'h0);
        tick();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            check("nto wait valid", 32'(bus_valid_o), 32'd1);
            check("nto wait err",   32'(core_err_o),  32'd0);
            tick();
        end
        @(negedge clk_i);
        check("nto be", 32'(bus_be_o), 32'hF);
        bus_ready_i = 1'b1;
        tick();
        bus_ready_i  = 1'b0;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hCAFE_F00D;
        tick();
        bus_rvalid_i = 1'b0;
        core_req_i   = 1'b0;
        @(negedge clk_i);
        check("nto rdata", core_rdata_o, 32'hCAFE_F00D);
        tick();
`endif

        // Reset in WAIT_RD: everything clears at once, late rvalid ignored.
        drive_req(1'b0, 32'h0000_0100, 2'd2, 32'h0);
        bus_ready_i = 1'b1;
        tick();
        tick();
        bus_ready_i = 1'b0;
        @(negedge clk_i);
        check("rwr in wait stall", 32'(core_stall_o), 32'd1);
        tick();
        #2;
        reset_ni = 1'b0;
        #1;
        check("rwr valid", 32'(bus_valid_o),  32'd0);
        check("rwr stall", 32'(core_stall_o), 32'd0);
        check("rwr rdata", core_rdata_o,      32'd0);
        check("rwr addr",  bus_addr_o,        32'd0);
        check("rwr be",    32'(bus_be_o),     32'd0);
        core_req_i = 1'b0;
        @(negedge clk_i);
        reset_ni = 1'b1;
        tick();
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hDEAD_BEEF;
        @(negedge clk_i);
        check("rwr late rvalid stall", 32'(core_stall_o), 32'd0);
        tick();
        bus_rvalid_i = 1'b0;
        @(negedge clk_i);
        check("rwr late rvalid rdata", core_rdata_o,     32'd0);
        check("rwr late valid",        32'(bus_valid_o), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_bus_adapter.md
DMEM_BUS_ADAPTER -- requirements
Module: dmem_bus_adapter

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter TIMEOUT_CYCLES SHALL be provided: default 255; it is the maximum number of cycles spent in REQ+WAIT_RD before abort.
REQ-003 The block SHALL have the following ports:
- clk_i  in  1  clock
- reset_ni  in  1  asynchronous active-low reset
- core_req_i  in  1  data access requested this cycle
- core_we_i  in  1  1=store, 0=load
- core_addr_i  in  32  byte address
- core_size_i  in  2  0=byte, 1=half, 2=word (3 illegal, treated as word)
- core_wdata_i  in  32  store data, LSB-justified
- core_rdata_o  out  32  load data, LSB-justified, zero-extended
- core_stall_o  out  1  hold pipeline
- core_misaligned_o  out  1  misaligned access pulse
- core_err_o  out  1  bus timeout pulse (TIMEOUT_EN only)
- bus_valid_o  out  1  request valid
- bus_ready_i  in  1  request accepted
- bus_we_o  out  1  write
- bus_addr_o  out  32  word address, bits [1:0]=0
- bus_be_o  out  4  byte enables
- bus_wdata_o  out  32  lane-replicated store data
- bus_rdata_i  in  32  read data
- bus_rvalid_i  in  1  read data valid

Function
REQ-004 The FSM SHALL have exactly four states: IDLE, REQ, WAIT_RD, DONE.
REQ-005 In IDLE, an aligned core_req_i SHALL latch we/addr/size/wdata and move to REQ next cycle; core_stall_o SHALL be 1 combinationally in that cycle.
REQ-006 In REQ, bus_valid_o SHALL be 1 and all bus_* outputs SHALL stay stable until bus_valid_o&bus_ready_i.
REQ-007 On handshake, a store SHALL go to DONE and a load SHALL go to WAIT_RD.
REQ-008 In WAIT_RD, bus_rvalid_i SHALL capture bus_rdata_i and move to DONE; rvalid outside WAIT_RD SHALL be ignored.
REQ-009 In DONE, core_stall_o SHALL be 0, core_rdata_o SHALL present captured data, and the next state SHALL be IDLE; the new request is not accepted in DONE.
REQ-010 core_stall_o SHALL be 1 in REQ and WAIT_RD, and 0 in IDLE without an aligned request.
REQ-011 bus_be_o SHALL be 0001<<a for byte, 0011<<a for half, and 1111 for word, where a=addr[1:0].
REQ-012 bus_wdata_o SHALL be {4{wdata[7:0]}} for byte, {2{wdata[15:0]}} for half, and wdata for word.
REQ-013 core_rdata_o SHALL be (bus_rdata_i>>8a) masked to 8/16/32 bits per size, with upper bits zero.
REQ-014 A half access with a[0]=1 or a word access with a!=0 SHALL start no bus transaction, pulse core_misaligned_o for one cycle, keep core_stall_o=0, and leave the FSM in IDLE.
REQ-015 core_rdata_o SHALL hold its value until the next load capture.

Reset
REQ-016 Reset assertion SHALL immediately force state=IDLE, and set bus_valid_o, core_stall_o, core_misaligned_o and core_err_o to 0, and core_rdata_o, bus_addr_o, bus_be_o and bus_wdata_o to 0, including mid-transaction.
REQ-017 An outstanding bus transaction aborted by reset SHALL be dropped; a late bus_rvalid_i SHALL be ignored.

Configuration
REQ-018 The macro DMEM_BUS_TIMEOUT_EN SHALL enable the timeout feature.
REQ-019 With DMEM_BUS_TIMEOUT_EN, a counter SHALL clear on IDLE->REQ and increment each cycle in REQ/WAIT_RD; reaching TIMEOUT_CYCLES SHALL go to DONE with core_rdata_o=0 and core_err_o=1 for that cycle.
REQ-020 Without DMEM_BUS_TIMEOUT_EN, there SHALL be no counter, core_err_o SHALL be tied 0, and waits SHALL be unbounded.

Verification
REQ-021 Store word 0x11223344 @0x100 with ready=1 immediately -> be=1111, addr=0x100, stall for 2 cycles, DONE on the 3rd cycle.
REQ-022 Load byte @0x103 with rdata=0xAABBCCDD, rvalid 2 cycles later -> be=1000, core_rdata_o=0x000000AA.
REQ-023 Store half 0xBEEF @0x102 with ready delayed 3 cycles -> bus outputs stable, be=1100, wdata=0xBEEFBEEF.
REQ-024 Load word @0x101 -> no bus_valid_o, core_misaligned_o=1 for one cycle, stall=0.
REQ-025 reset_ni low in WAIT_RD -> immediate IDLE, valid=0; rvalid after release is ignored.
REQ-026 With DMEM_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, ready held 0 -> core_err_o=1 at the 4th wait cycle, rdata=0.
